// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin index arbiter and its picker.
package arb_pkg;

   typedef enum logic {IDLE, GRANT} state_t;

   localparam int N_DEF        = 5;
   localparam int MAX_HOLD_DEF = 16;
   localparam int HOLD_W_DEF   = 8;

   function automatic int REQ_W(input int n);
      return 2 ** n;
   endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick_first
   import arb_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [REQ_W(N)-1:0] req_i,
   input  logic [N-1:0]        ptr_i,
   output logic                any_req_o,
   output logic [N-1:0]        sel_idx_o
);

   localparam int W = REQ_W(N);

   logic [2*W-1:0] dbl;
   logic [W-1:0]   rot;
   logic [N-1:0]   off;

   always_comb begin
      // Rotating the doubled vector puts requester ptr at bit 0.
      dbl = {req_i, req_i} >> ptr_i;
      rot = dbl[W-1:0];
      off = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (rot[i]) off = N'(i);
      end
      any_req_o = |req_i;
      sel_idx_o = ptr_i + off;
   end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter driving a binary grant index + valid into a one-hot decoder.
module rr_index_arbiter
   import arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int HOLD_W   = HOLD_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REQ_W(N)-1:0] req_i,
   input  logic                release_i,
   output logic [N-1:0]        grant_idx_o,
   output logic                grant_valid_o,
   output logic                timeout_o
);

   state_t              state_q, state_d;
   logic [N-1:0]        ptr_q, ptr_d;
   logic [N-1:0]        grant_idx_q, grant_idx_d;
   logic                grant_valid_q, grant_valid_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                timeout_q, timeout_d;

   logic                any_req;
   logic [N-1:0]        sel_idx;
   logic                hold_expired;

   rr_pick_first #(.N(N)) u_pick (
      .req_i     (req_i),
      .ptr_i     (ptr_q),
      .any_req_o (any_req),
      .sel_idx_o (sel_idx)
   );

   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD));

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      hold_cnt_d    = hold_cnt_q;
      timeout_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_idx_d   = sel_idx;
               grant_valid_d = 1'b1;
               hold_cnt_d    = HOLD_W'(1);
               state_d       = GRANT;
            end
         end
         GRANT: begin
            // Release outranks withdrawal, which outranks the hold timeout.
            if (release_i || !req_i[grant_idx_q] || hold_expired) begin
               timeout_d     = !release_i && req_i[grant_idx_q];
               grant_valid_d = 1'b0;
               hold_cnt_d    = '0;
               ptr_d         = grant_idx_q + N'(1);
               state_d       = IDLE;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         hold_cnt_q    <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         hold_cnt_q    <= hold_cnt_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant_idx_o   = grant_idx_q;
   assign grant_valid_o = grant_valid_q;
   assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed bench for rr_index_arbiter with an inline model of the downstream decoder.
module tb_rr_index_arbiter;
   import arb_pkg::*;

   localparam int N = 5;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  req;
   logic          rel;
   logic [N-1:0]  gidx;
   logic          gvld;
   logic          tmo;
   logic [W-1:0]  y;

   int n_chk = 0;
   int n_fail = 0;

   rr_index_arbiter #(.N(N), .MAX_HOLD(16), .HOLD_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req),
      .release_i     (rel),
      .grant_idx_o   (gidx),
      .grant_valid_o (gvld),
      .timeout_o     (tmo)
   );

   always #5 clk = ~clk;

   // One-hot decoder fed by grant_idx/grant_valid.
   assign y = gvld ? (W'(1) << gidx) : '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      rel = 1'b0;
      step();
      check("rst_valid", 32'(gvld), 0);
      check("rst_idx", 32'(gidx), 0);
      check("rst_timeout", 32'(tmo), 0);

      rst = 1'b0;
      step();
      check("idle_noreq", 32'(gvld), 0);

      // Reset in the middle of a grant to 7
      req = 32'h0000_0080;
      step();
      check("pre_rst_idx", 32'(gidx), 7);
      check("pre_rst_valid", 32'(gvld), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(gvld), 0);
      check("async_rst_idx", 32'(gidx), 0);
      step();
      rst = 1'b0;
      req = 32'h0000_0001;
      step();
      check("post_rst_idx", 32'(gidx), 0);
      check("post_rst_valid", 32'(gvld), 1);
      req = '0;
      step();
      check("withdraw0_valid", 32'(gvld), 0);

      // Single request, release -> ptr 3
      req = 32'h0000_0004;
      step();
      check("single_idx", 32'(gidx), 2);
      check("single_valid", 32'(gvld), 1);
      rel = 1'b1;
      step();
      check("single_rel_valid", 32'(gvld), 0);
      check("single_rel_idx_hold", 32'(gidx), 2);
      check("single_rel_timeout", 32'(tmo), 0);

      // ptr=3, bits 1 and 4 -> 4 then 1
      rel = 1'b0;
      req = 32'h0000_0012;
      step();
      check("fair_first", 32'(gidx), 4);
      rel = 1'b1;
      step();
      check("fair_gap", 32'(gvld), 0);
      rel = 1'b0;
      step();
      check("fair_second", 32'(gidx), 1);
      check("fair_second_valid", 32'(gvld), 1);
      rel = 1'b1;
      step();
      check("fair_second_end", 32'(gvld), 0);

      // Timeout on requester 5 after 16 grant cycles
      rel = 1'b0;
      req = 32'h0000_0020;
      step();
      check("to_grant_idx", 32'(gidx), 5);
      for (int i = 0; i < 15; i++) begin
         step();
         check("to_hold_valid", 32'(gvld), 1);
         check("to_hold_notimeout", 32'(tmo), 0);
      end
      req = 32'h0000_0060;
      step();
      check("to_pulse", 32'(tmo), 1);
      check("to_valid_drop", 32'(gvld), 0);
      step();
      check("to_ptr6_idx", 32'(gidx), 6);
      check("to_pulse_end", 32'(tmo), 0);
      for (int i = 0; i < 15; i++) step();
      check("rel_to_still_valid", 32'(gvld), 1);
      rel = 1'b1;
      step();
      check("rel_to_valid", 32'(gvld), 0);
      check("rel_to_no_pulse", 32'(tmo), 0);

      // Withdrawal with decoder output, ptr now 7
      rel = 1'b0;
      req = 32'h0000_0200;
      step();
      check("dec_idx", 32'(gidx), 9);
      check("dec_y", y, 32'h0000_0200);
      req = '0;
      step();
      check("dec_withdraw_valid", 32'(gvld), 0);
      check("dec_y_idle", y, 0);
      step();
      check("dec_y_idle2", y, 0);

      // Full rotation with all requests and release held
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = '1;
      rel = 1'b1;
      for (int i = 0; i < 33; i++) begin
         step();
         check("rot_idx", 32'(gidx), 32'(i % 32));
         check("rot_valid", 32'(gvld), 1);
         step();
         check("rot_gap", 32'(gvld), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the N-bit one-hot decoder.
- Accepts 2**N request lines and selects one requester fairly.
- Drives that requester's binary index plus a valid strobe. These connect straight to the decoder's `a` and `enable` inputs, so the decoder's y becomes the one-hot grant vector.
- Grants are held until released, dropped by the requester, or timed out.

Parameters:
- N, 5, index width; the request vector is 2**N bits wide and drives decoder parameter N.
- MAX_HOLD, 16, maximum grant length in cycles; 0 disables the timeout.
- HOLD_W, 8, width of the hold counter; MAX_HOLD must be < 2**HOLD_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2**N  request lines; bit i = requester i.
- release  in  1  one-cycle pulse from the current owner ending its grant.
- grant_idx  out  N  index of the granted requester; connects to decoder `a`.
- grant_valid  out  1  grant active; connects to decoder `enable`.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, any time, including mid-grant):
  - state=IDLE, grant_idx=0, grant_valid=0, timeout=0.
  - ptr=0, hold_cnt=0.
  - Outputs are valid immediately on rst assertion.
- Registered state: ptr (N bits), grant_idx, grant_valid, hold_cnt, timeout.
- All outputs are registered; nothing is combinational from req or release to an output.
- IDLE:
  - If req!=0, select the first set bit scanning upward from ptr, wrapping from 2**N-1 to 0.
  - Next edge: grant_idx=selected, grant_valid=1, hold_cnt=1, state=GRANT.
  - If req==0: remain in IDLE with outputs unchanged (grant_valid stays 0).
  - Request-to-grant latency: 1 cycle.
- GRANT: grant_idx is stable throughout. End conditions, in priority order:
  - (a) release=1.
  - (b) req[grant_idx]=0 (requester withdrew).
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD; timeout pulses high for exactly this one edge.
  - On any end condition, next edge: grant_valid=0, ptr=grant_idx+1 (mod 2**N), state=IDLE.
  - Otherwise hold_cnt increments, saturating at 2**HOLD_W-1.
- After every grant there is at least one cycle with grant_valid=0 (IDLE). No back-to-back re-grant in the same edge.
- Simultaneous events:
  - release and timeout on the same cycle → treated as release; no timeout pulse.
  - release while in IDLE → ignored.
  - Requests that rise during GRANT wait until the next IDLE arbitration.
- Fairness:
  - The just-served index has the lowest priority next round.
  - With all 2**N requests held, grants cycle 0,1,...,2**N-1,0.
- ptr wrap: grant_idx=2**N-1 → ptr=0.
- grant_idx retains its last value while grant_valid=0; only grant_valid qualifies it.

Decomposition:
- Shared package `arb_pkg`:
  - state enum {IDLE, GRANT};
  - default constants for N, MAX_HOLD and HOLD_W;
  - request width function REQ_W(N)=2**N.
- Sub-module `rr_pick_first` (combinational):
  - inputs req and ptr; outputs any_req and sel_idx.
  - implementation: rotate req right by ptr, apply a priority encoder, add ptr back mod 2**N.
  - Unit-testable on its own.
- Top level: FSM, ptr, hold counter and output registers.

Test Plan:
- Reset mid-grant: rst asserted while grant_idx=7, grant_valid=1 → grant_valid=0, grant_idx=0 immediately; after rst falls with req=0x0000_0001, next grant is idx 0.
- Single request: req=0x0000_0004 → one cycle later grant_idx=2, grant_valid=1; release pulse → grant_valid=0 next cycle, ptr=3.
- Rotation/wrap: req=0xFFFF_FFFF held, release asserted each GRANT cycle → grant sequence 0,1,...,31,0 with one idle cycle between grants.
- Fairness from pointer: ptr=3, req=0x0000_0012 (bits 1,4) → idx 4 granted; after release → idx 1 granted.
- Timeout: MAX_HOLD=16, req bit 5 held, no release → after 16 GRANT cycles timeout pulses once, grant_valid drops, ptr=6; release and timeout on the same cycle → timeout stays 0.
- Withdrawal plus decoder hookup: instantiate with decoder N=5, grant idx 9, then req[9] cleared → grant ends next edge; while granted, decoder y=0x0000_0200; otherwise y=0.
